// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: FSM states, rounding-mode constants and operand
// classification shared by the parametrised FP multiplier.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MULT,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CL_ZERO,
    CL_NORMAL,
    CL_INF,
    CL_NAN
  } fclass_t;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  // Width-independent: callers reduce their fields to these three bits.
  function automatic fclass_t classify(
    input logic exp_zero,
    input logic exp_ones,
    input logic frac_zero
  );
    fclass_t c;
    c = CL_NORMAL;
    if (exp_zero)
      c = CL_ZERO;
    else if (exp_ones)
      c = frac_zero ? CL_INF : CL_NAN;
    return c;
  endfunction

endpackage

// File: rtl/fp_mul_shift_add.sv
// fp_mul_shift_add: iterative N x N unsigned multiplier, one bit per
// enabled cycle; the caller decides how many cycles to run it.
module fp_mul_shift_add #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           en,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product
);

  logic [2*N-1:0] r_mcand;
  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_mplier;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
    end else if (load) begin
      r_mcand  <= {{N{1'b0}}, multiplicand};
      r_mplier <= multiplier;
      r_acc    <= '0;
    end else if (en) begin
      if (r_mplier[0])
        r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign product = r_acc;

endmodule

// File: rtl/fp_mul_param.sv
// fp_mul_param: multi-cycle parametrised FP multiplier, start/done handshake.
// FP_MUL_PARAM_RNE_EN compiles in round-nearest-even; otherwise RTZ only.
module fp_mul_param
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         rnd_mode_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] product_o,
  output logic         nan_o,
  output logic         inifinit_o,
  output logic         overflow_o,
  output logic         underflow_o
);

  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(SW + 1);
  localparam logic signed [EW-1:0] P_BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] P_EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] P_QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t r_state, w_next;

  logic [W-1:0]         r_a, r_b;
  logic                 r_sign;
  logic signed [EW-1:0] r_exp;
  logic [CW-1:0]        r_cnt;
  logic [MAN_W:0]       r_man;
  logic                 r_g, r_s;

  logic [W-1:0] r_prod;
  logic         r_nan, r_inf, r_ovf, r_unf;

  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  fclass_t          w_ca, w_cb;
  logic             w_sign, w_capture;
  logic             w_sp_nan, w_sp_inf, w_sp_zero, w_special;
  logic [W-1:0]     w_sp_res;

  assign w_ea = r_a[W-2:MAN_W];
  assign w_eb = r_b[W-2:MAN_W];
  assign w_fa = r_a[MAN_W-1:0];
  assign w_fb = r_b[MAN_W-1:0];
  assign w_ca = classify(w_ea == '0, &w_ea, w_fa == '0);
  assign w_cb = classify(w_eb == '0, &w_eb, w_fb == '0);
  assign w_sign = r_a[W-1] ^ r_b[W-1];

  assign w_sp_nan = (w_ca == CL_NAN) || (w_cb == CL_NAN)
                 || (w_ca == CL_INF && w_cb == CL_ZERO)
                 || (w_ca == CL_ZERO && w_cb == CL_INF);
  assign w_sp_inf = !w_sp_nan
                 && (w_ca == CL_INF || w_cb == CL_INF);
  assign w_sp_zero = !w_sp_nan
                  && (w_ca == CL_ZERO || w_cb == CL_ZERO);
  assign w_special = w_sp_nan | w_sp_inf | w_sp_zero;

  always_comb begin
    w_sp_res = {w_sign, {(W-1){1'b0}}};
    if (w_sp_nan)
      w_sp_res = P_QNAN;
    else if (w_sp_inf)
      w_sp_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic [PW-1:0] w_prod;
  logic          w_sa_load, w_sa_en;

  assign w_sa_load = (r_state == S_LOAD);
  assign w_sa_en   = (r_state == S_MULT);

  fp_mul_shift_add #(.N(SW)) u_sa (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (w_sa_load),
    .en           (w_sa_en),
    .multiplicand ({1'b1, w_fa}),
    .multiplier   ({1'b1, w_fb}),
    .product      (w_prod)
  );

  // Product of two 1.x significands lies in [1,4); bit shifted out joins sticky.
  logic          w_hi;
  logic [PW-2:0] w_nrm;

  assign w_hi  = w_prod[PW-1];
  assign w_nrm = w_hi ? w_prod[PW-1:1] : w_prod[PW-2:0];

  logic w_inc;
`ifdef FP_MUL_PARAM_RNE_EN
  logic r_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rnd <= RND_RNE;
    else if (w_capture)
      r_rnd <= rnd_mode_i;
  end

  assign w_inc = (r_rnd == RND_RNE) & r_g & (r_s | r_man[0]);
`else
  logic w_unused_rnd;

  assign w_inc = 1'b0;
  assign w_unused_rnd = ^{rnd_mode_i, r_g, r_s};
`endif

  logic [MAN_W+1:0]     w_sum;
  logic                 w_cy;
  logic [MAN_W-1:0]     w_frac;
  logic signed [EW-1:0] w_expf;
  logic                 w_ovf, w_unf;

  assign w_sum  = {1'b0, r_man} + {{(MAN_W+1){1'b0}}, w_inc};
  assign w_cy   = w_sum[MAN_W+1];
  assign w_frac = w_cy ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
  assign w_expf = r_exp + $signed({{(EW-1){1'b0}}, w_cy});
  assign w_ovf  = !w_expf[EW-1] && (w_expf >= P_EMAX);
  assign w_unf  = w_expf[EW-1] || (w_expf == '0);

  assign w_capture = (r_state == S_IDLE || r_state == S_DONE) && start_i;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i) w_next = S_LOAD;
      S_LOAD:  w_next = w_special ? S_DONE : S_MULT;
      S_MULT:  if (r_cnt == CW'(MAN_W)) w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  w_next = start_i ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_cnt   <= '0;
      r_man   <= '0;
      r_g     <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_a <= a_i;
        r_b <= b_i;
      end
      if (r_state == S_LOAD) begin
        r_sign <= w_sign;
        r_exp  <= $signed({2'b00, w_ea})
                + $signed({2'b00, w_eb}) - P_BIAS;
        r_cnt  <= '0;
      end
      if (r_state == S_MULT)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_NORM) begin
        r_exp <= r_exp + $signed({{(EW-1){1'b0}}, w_hi});
        r_man <= w_nrm[2*MAN_W:MAN_W];
        r_g   <= w_nrm[MAN_W-1];
        r_s   <= (|w_nrm[MAN_W-2:0]) | (w_hi & w_prod[0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_nan  <= 1'b0;
      r_inf  <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else if (r_state == S_LOAD && w_special) begin
      r_prod <= w_sp_res;
      r_nan  <= w_sp_nan;
      r_inf  <= w_sp_inf;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else if (r_state == S_ROUND) begin
      r_nan <= 1'b0;
      r_inf <= w_ovf;
      r_ovf <= w_ovf;
      r_unf <= !w_ovf && w_unf;
      if (w_ovf)
        r_prod <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (w_unf)
        r_prod <= {r_sign, {(W-1){1'b0}}};
      else
        r_prod <= {r_sign, w_expf[EXP_W-1:0], w_frac};
    end
  end

  assign busy_o      = (r_state == S_LOAD) || (r_state == S_MULT)
                    || (r_state == S_NORM) || (r_state == S_ROUND);
  assign done_o      = (r_state == S_DONE);
  assign product_o   = r_prod;
  assign nan_o       = r_nan;
  assign inifinit_o  = r_inf;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_unf;

endmodule

// File: tb/tb_fp_mul_param.sv
// tb_fp_mul_param: directed checks of fp_mul_param in single and half
// precision, plus back-to-back random vectors against a real-valued model.
module tb_fp_mul_param;

`ifdef FP_MUL_PARAM_RNE_EN
  localparam bit RNE_ON = 1'b1;
  localparam logic [31:0] EXP_RNE = 32'h40100002;
`else
  localparam bit RNE_ON = 1'b0;
  localparam logic [31:0] EXP_RNE = 32'h40100001;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        rnd_mode_i = 1'b0;
  logic        busy_o, done_o;
  logic [31:0] product_o;
  logic        nan_o, inf_o, ovf_o, unf_o;

  logic        h_start = 1'b0;
  logic [15:0] h_a = '0;
  logic [15:0] h_b = '0;
  logic        h_busy, h_done;
  logic [15:0] h_prod;
  logic        h_nan, h_inf, h_ovf, h_unf;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fp_mul_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .rnd_mode_i  (rnd_mode_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .product_o   (product_o),
    .nan_o       (nan_o),
    .inifinit_o  (inf_o),
    .overflow_o  (ovf_o),
    .underflow_o (unf_o)
  );

  fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (h_start),
    .a_i         (h_a),
    .b_i         (h_b),
    .rnd_mode_i  (rnd_mode_i),
    .busy_o      (h_busy),
    .done_o      (h_done),
    .product_o   (h_prod),
    .nan_o       (h_nan),
    .inifinit_o  (h_inf),
    .overflow_o  (h_ovf),
    .underflow_o (h_unf)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit h, input logic [31:0] a,
                     input logic [31:0] b, input logic rnd,
                     output logic [31:0] p, output logic [3:0] fl,
                     output int lat, output logic bz0,
                     output logic bzd);
    @(negedge clk);
    if (h) begin
      h_a = a[15:0];
      h_b = b[15:0];
      h_start = 1'b1;
    end else begin
      a_i = a;
      b_i = b;
      start_i = 1'b1;
    end
    rnd_mode_i = rnd;
    @(posedge clk);
    #1;
    h_start = 1'b0;
    start_i = 1'b0;
    bz0 = h ? h_busy : busy_o;
    lat = 0;
    while (!(h ? h_done : done_o) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p   = h ? {16'h0, h_prod} : product_o;
    fl  = h ? {h_nan, h_inf, h_ovf, h_unf}
            : {nan_o, inf_o, ovf_o, unf_o};
    bzd = h ? h_busy : busy_o;
  endtask

  // Exact double product of two singles, rounded back to single.
  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input bit rne);
    real ra, rb;
    logic [10:0] ea, eb;
    logic [63:0] d;
    logic [31:0] t;
    int e;
    ea = {3'b000, a[30:23]} + 11'd896;
    eb = {3'b000, b[30:23]} + 11'd896;
    ra = $bitstoreal({a[31], ea, a[22:0], 29'd0});
    rb = $bitstoreal({b[31], eb, b[22:0], 29'd0});
    d = $realtobits(ra * rb);
    e = int'(d[62:52]) - 896;
    t = {d[63], 8'(e), d[51:29]};
    if (rne && d[28] && ((|d[27:0]) || d[29]))
      t = t + 32'd1;
    return t;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(100, 154));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  initial begin
    logic [31:0] p, ca, cb, na, nb;
    logic [3:0]  fl;
    logic        b0, bd;
    int          lat, pulses;

    na = '0;
    nb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prod", product_o, 0);
    chk("rst_busy_done", {busy_o, done_o}, 0);
    chk("rst_flags", {nan_o, inf_o, ovf_o, unf_o}, 0);
    chk("rst_half", {h_busy, h_done, h_prod}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 32'h40400000, 32'h40000000, 0, p, fl, lat, b0, bd);
    chk("mul_3x2", p, 32'h40C00000);
    chk("lat_3x2", lat, 27);
    chk("flags_3x2", fl, 0);
    chk("busy_in_load", b0, 1);
    chk("busy_at_done", bd, 0);

    run(0, 32'h3FC00001, 32'h3FC00001, 0, p, fl, lat, b0, bd);
    chk("round_rne", p, EXP_RNE);
    run(0, 32'h3FC00001, 32'h3FC00001, 1, p, fl, lat, b0, bd);
    chk("round_rtz", p, 32'h40100001);

    run(0, 32'h7F000000, 32'h7F000000, 0, p, fl, lat, b0, bd);
    chk("ovf_prod", p, 32'h7F800000);
    chk("ovf_flags", fl, 4'b0110);
    run(0, 32'h00800000, 32'h00800000, 0, p, fl, lat, b0, bd);
    chk("unf_prod", p, 32'h00000000);
    chk("unf_flags", fl, 4'b0001);

    run(0, 32'h7F800000, 32'h00000000, 0, p, fl, lat, b0, bd);
    chk("inf0_prod", p, 32'h7FC00000);
    chk("inf0_flags", fl, 4'b1000);
    chk("inf0_lat", lat, 1);
    run(0, 32'hFF800000, 32'h40000000, 0, p, fl, lat, b0, bd);
    chk("ninf_prod", p, 32'hFF800000);
    chk("ninf_flags", fl, 4'b0100);
    chk("ninf_lat", lat, 1);
    run(0, 32'h7FC12345, 32'h3F800000, 0, p, fl, lat, b0, bd);
    chk("nan_in_prod", p, 32'h7FC00000);
    chk("nan_in_flags", fl, 4'b1000);
    run(0, 32'h80000000, 32'h40000000, 0, p, fl, lat, b0, bd);
    chk("nzero_prod", p, 32'h80000000);
    chk("nzero_flags", fl, 4'b0000);
    run(0, 32'h00000001, 32'h7F000000, 0, p, fl, lat, b0, bd);
    chk("subn_flush", p, 32'h00000000);
    chk("subn_lat", lat, 1);

    ca = gen();
    cb = gen();
    @(negedge clk);
    a_i = ca;
    b_i = cb;
    rnd_mode_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      if (i < 99) begin
        na = gen();
        nb = gen();
        a_i = na;
        b_i = nb;
      end else begin
        start_i = 1'b0;
      end
      lat = 0;
      while (!done_o && lat < 100) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("b2b_%0d_%h_%h", i, ca, cb), product_o,
          model(ca, cb, RNE_ON));
      ca = na;
      cb = nb;
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    a_i = 32'h40400000;
    b_i = 32'h40000000;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_prod", product_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_done", done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done_o) pulses++;
    end
    chk("rst_no_done", pulses, 0);
    run(0, 32'hC0400000, 32'h40000000, 0, p, fl, lat, b0, bd);
    chk("post_rst_prod", p, 32'hC0C00000);
    chk("post_rst_lat", lat, 27);

    run(1, 32'h00004200, 32'h00004000, 0, p, fl, lat, b0, bd);
    chk("half_prod", p, 32'h00004600);
    chk("half_lat", lat, 14);
    chk("half_flags", fl, 0);
    run(1, 32'h00007800, 32'h00007800, 0, p, fl, lat, b0, bd);
    chk("half_ovf_prod", p, 32'h00007C00);
    chk("half_ovf_flags", fl, 4'b0110);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
